// File: rtl/sram_pkg.sv
// Shared types for the SRAM pin responder: FSM states, byte-lane masks and lane width.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } sram_state_e;

    typedef logic [1:0] lane_mask_t;

    localparam int DW_DEFAULT = 16;
    localparam int LANE_W     = DW_DEFAULT / 2;

    function automatic int lane_width(input int dw);
        return dw / 2;
    endfunction

endpackage

// File: rtl/sram_pin_sync.sv
// Generic N-bit, STAGES-deep flop chain used to bring async SRAM pins into the clk domain.
module sram_pin_sync #(
    parameter int             W         = 1,
    parameter int             STAGES    = 2,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VAL;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sram_responder.sv
// Behaves as an async SRAM device on the pin side, backed by inferred block RAM.
// Optional macro SRAM_RESPONDER_STATS_EN adds wr_count/rd_count activity counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int AW          = 14,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_dq_i,
    output logic [DW-1:0] sram_dq_o,
    output lane_mask_t    sram_dq_oe,
    input  logic          sram_we_n,
    input  logic          sram_oe_n,
    input  logic          sram_ub_n,
    input  logic          sram_lb_n
`ifdef SRAM_RESPONDER_STATS_EN
   ,output logic [31:0]   wr_count,
    output logic [31:0]   rd_count
`endif
);

    localparam int LW = lane_width(DW);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("sram_responder: SYNC_STAGES must be 2 or 3");
    end
    if (DW % 2 != 0) begin : g_bad_dw
        $error("sram_responder: DW must be even");
    end

    logic [3:0]       sync_ctrl;
    logic [AW+DW-1:0] sync_data;
    logic             sync_we_n, sync_oe_n, sync_ub_n, sync_lb_n;
    logic [AW-1:0]    sync_addr;
    logic [DW-1:0]    sync_dq_i;

    sram_pin_sync #(.W(4), .STAGES(SYNC_STAGES), .RESET_VAL(4'b1111)) u_ctrl_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}),
        .q       (sync_ctrl)
    );

    sram_pin_sync #(.W(AW+DW), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_data_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({sram_addr, sram_dq_i}),
        .q       (sync_data)
    );

    assign {sync_we_n, sync_oe_n, sync_ub_n, sync_lb_n} = sync_ctrl;
    assign {sync_addr, sync_dq_i}                       = sync_data;

    sram_state_e   state, next_state;
    logic          we_n_prev;
    logic          we_rise;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_ub_n, hold_lb_n;
    logic          commit;
    lane_mask_t    commit_be;
    logic          rd_en;

    assign we_rise   = sync_we_n & ~we_n_prev;
    assign commit    = (state == WRITE) && we_rise;
    assign commit_be = {~hold_ub_n, ~hold_lb_n};
    assign rd_en     = (next_state == READ);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!sync_we_n)      next_state = WRITE;
                else if (!sync_oe_n) next_state = READ;
            end
            WRITE: begin
                if (we_rise)         next_state = IDLE;
            end
            READ: begin
                if (!sync_we_n)      next_state = WRITE;
                else if (sync_oe_n)  next_state = IDLE;
            end
            default:                 next_state = IDLE;
        endcase
    end

    // Hold registers track the bus while we_n is low so the commit uses the last stable value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            we_n_prev <= 1'b1;
            hold_addr <= '0;
            hold_data <= '0;
            hold_ub_n <= 1'b1;
            hold_lb_n <= 1'b1;
        end else begin
            state     <= next_state;
            we_n_prev <= sync_we_n;
            if (!sync_we_n) begin
                hold_addr <= sync_addr;
                hold_data <= sync_dq_i;
                hold_ub_n <= sync_ub_n;
                hold_lb_n <= sync_lb_n;
            end
        end
    end

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data;

    // Commit (WRITE->IDLE) and read enable (next state READ) are never active together,
    // so a read always sees data committed on an earlier edge without a bypass path.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (commit_be[1]) mem[hold_addr][DW-1:LW] <= hold_data[DW-1:LW];
            if (commit_be[0]) mem[hold_addr][LW-1:0]  <= hold_data[LW-1:0];
        end
        if (rd_en) begin
            rd_data <= mem[sync_addr];
        end
    end

    lane_mask_t rd_lanes;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_lanes   <= 2'b00;
            sram_dq_o  <= '0;
            sram_dq_oe <= 2'b00;
        end else begin
            rd_lanes <= rd_en ? {~sync_ub_n, ~sync_lb_n} : 2'b00;
            if (rd_en) begin
                sram_dq_oe <= rd_lanes;
                sram_dq_o  <= {{LW{rd_lanes[1]}} & rd_data[DW-1:LW],
                               {LW{rd_lanes[0]}} & rd_data[LW-1:0]};
            end else begin
                sram_dq_oe <= 2'b00;
                sram_dq_o  <= '0;
            end
        end
    end

`ifdef SRAM_RESPONDER_STATS_EN
    logic [31:0] wr_cnt, rd_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (commit && (commit_be != 2'b00)) wr_cnt <= wr_cnt + 32'd1;
            if ((state == IDLE) && (next_state == READ)) rd_cnt <= rd_cnt + 32'd1;
        end
    end

    assign wr_count = wr_cnt;
    assign rd_count = rd_cnt;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder against an associative-array memory model.
module tb_sram_responder;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_i;
    logic [DW-1:0] sram_dq_o;
    logic [1:0]    sram_dq_oe;
    logic          sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_RESPONDER_STATS_EN
    logic [31:0]   wr_count, rd_count;
`endif

    sram_responder #(.AW(AW), .DW(DW), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
`ifdef SRAM_RESPONDER_STATS_EN
       ,.wr_count   (wr_count),
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_wr   = 0;
    int exp_rd   = 0;
    logic [15:0] model [int];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expect_read(input logic [AW-1:0] a, input logic ub_n, input logic lb_n);
        logic [15:0] w = model[int'(a)];
        return {ub_n ? 8'h00 : w[15:8], lb_n ? 8'h00 : w[7:0]};
    endfunction

    // One SRAM write cycle: we_n low for 4 clk, then settle long enough for the commit.
    task automatic apply_write(input logic [AW-1:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
        logic [15:0] w;
        @(negedge clk);
        sram_addr = a; sram_dq_i = d; sram_ub_n = ub_n; sram_lb_n = lb_n; sram_we_n = 1'b0;
        repeat (4) @(negedge clk);
        sram_we_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        w = model.exists(int'(a)) ? model[int'(a)] : 16'hxxxx;
        if (!ub_n) w[15:8] = d[15:8];
        if (!lb_n) w[7:0]  = d[7:0];
        model[int'(a)] = w;
        if (!ub_n || !lb_n) exp_wr++;
    endtask

    // One read burst with exact entry and exit latency checks.
    task automatic apply_read(input logic [AW-1:0] a, input logic ub_n, input logic lb_n, input string tag);
        logic [15:0] exp_d;
        logic [1:0]  lanes;
        exp_d = expect_read(a, ub_n, lb_n);
        lanes = {~ub_n, ~lb_n};
        @(negedge clk);
        sram_addr = a; sram_ub_n = ub_n; sram_lb_n = lb_n; sram_oe_n = 1'b0;
        repeat (S + 1) @(posedge clk);
        #1 check_output({tag, "_oe_early"}, 32'(sram_dq_oe), 32'd0);
        @(posedge clk);
        #1;
        check_output({tag, "_data"}, 32'(sram_dq_o), 32'(exp_d));
        check_output({tag, "_oe"}, 32'(sram_dq_oe), 32'(lanes));
        @(negedge clk);
        sram_oe_n = 1'b1;
        repeat (S) @(posedge clk);
        #1 check_output({tag, "_oe_hold"}, 32'(sram_dq_oe), 32'(lanes));
        @(posedge clk);
        #1 check_output({tag, "_oe_drop"}, 32'(sram_dq_oe), 32'd0);
        exp_rd++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        sram_we_n = 1'b1; sram_oe_n = 1'b1; sram_ub_n = 1'b1; sram_lb_n = 1'b1;
        sram_addr = '0; sram_dq_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_dq_o", 32'(sram_dq_o), 32'd0);
        check_output("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] full write then read");
        apply_write(14'h0012, 16'hBEEF, 1'b0, 1'b0);
        apply_read(14'h0012, 1'b0, 1'b0, "full_rd");

        $display("[TB] byte lane writes and reads");
        apply_write(14'h0001, 16'h1234, 1'b0, 1'b0);
        apply_write(14'h0001, 16'hAB00, 1'b0, 1'b1);
        apply_read(14'h0001, 1'b0, 1'b0, "lane_both");
        apply_read(14'h0001, 1'b1, 1'b0, "lane_lower");
        apply_write(14'h0001, 16'hFFFF, 1'b1, 1'b1);
        apply_read(14'h0001, 1'b0, 1'b0, "no_lane_write");

        $display("[TB] write priority over read at top address");
        @(negedge clk);
        sram_addr = 14'h3FFF; sram_dq_i = 16'h5A5A; sram_ub_n = 1'b0; sram_lb_n = 1'b0;
        sram_we_n = 1'b0; sram_oe_n = 1'b0;
        for (int i = 0; i < S + 4; i++) begin
            @(posedge clk);
            #1 check_output("prio_oe_off", 32'(sram_dq_oe), 32'd0);
        end
        @(negedge clk);
        sram_we_n = 1'b1;
        model[int'(14'h3FFF)] = 16'h5A5A;
        exp_wr++;
        exp_rd++;
        repeat (S + 4) @(posedge clk);
        #1;
        check_output("prio_rd_data", 32'(sram_dq_o), 32'h5A5A);
        check_output("prio_rd_oe", 32'(sram_dq_oe), 32'd3);
        @(negedge clk);
        sram_oe_n = 1'b1;
        repeat (S + 3) @(negedge clk);

        $display("[TB] reset during write");
        apply_write(14'h0100, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        sram_addr = 14'h0100; sram_dq_i = 16'hDEAD; sram_ub_n = 1'b0; sram_lb_n = 1'b0; sram_we_n = 1'b0;
        repeat (S + 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check_output("midrst_dq_o", 32'(sram_dq_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sram_we_n = 1'b1;
        exp_wr = 0;
        exp_rd = 0;
        repeat (3) @(negedge clk);
        apply_read(14'h0100, 1'b0, 1'b0, "midrst_rd");

        $display("[TB] streaming read");
        for (int i = 0; i < 8; i++) begin
            apply_write(AW'(i), 16'(i * 16'h1111), 1'b0, 1'b0);
        end
        @(negedge clk);
        sram_addr = '0; sram_ub_n = 1'b0; sram_lb_n = 1'b0; sram_oe_n = 1'b0;
        exp_rd++;
        repeat (S + 3) @(posedge clk);
        for (int k = 0; k < 24 + S + 1; k++) begin
            @(negedge clk);
            sram_addr = (k < 24) ? AW'(k / 3) : AW'(7);
            @(posedge clk);
            #1;
            if (k >= S + 1) begin
                check_output("stream_data", 32'(sram_dq_o), 32'(model[(k - S - 1) / 3]));
            end
        end
        @(negedge clk);
        sram_oe_n = 1'b1;
        repeat (S + 3) @(negedge clk);

        $display("[TB] randomized writes and reads");
        for (int i = 0; i < 8; i++) begin
            apply_write(AW'(14'h0200 + i), 16'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            apply_write(AW'(14'h0200 + $urandom_range(0, 7)), 16'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            apply_read(AW'(14'h0200 + $urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_rd");
        end

`ifdef SRAM_RESPONDER_STATS_EN
        $display("[TB] activity counters");
        check_output("wr_count", wr_count, 32'(exp_wr));
        check_output("rd_count", rd_count, 32'(exp_rd));
        @(negedge clk);
        force dut.wr_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wr_cnt;
        apply_write(14'h0300, 16'h0F0F, 1'b0, 1'b0);
        check_output("wr_count_wrap", wr_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
